// File: rtl/raybox_pkg.sv
// Shared constants and types for the raybox pixel path: palette and the
// column record layout used by the column store.
package raybox_pkg;

    localparam logic [5:0] CEIL_RGB   = 6'b010101;
    localparam logic [5:0] FLOOR_RGB  = 6'b101010;
    localparam logic [5:0] WALL_LIGHT = 6'b111100;
    localparam logic [5:0] WALL_DARK  = 6'b101000;

    localparam int HBITS_DEF = 10;

    // Column record as stored: side bit above the height field.
    typedef struct packed {
        logic                 side;
        logic [HBITS_DEF-1:0] height;
    } column_t;

endpackage

// File: rtl/column_store.sv
// Double-buffered column store: writes go to the back bank, registered
// reads come from the front bank selected by front_sel.
module column_store #(
    parameter int COLS = 640,
    parameter int AW   = 10,
    parameter int W    = 11
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          front_sel,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] bank0 [COLS];
    logic [W-1:0] bank1 [COLS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel) bank0[wr_addr] <= wr_data;
            else           bank1[wr_addr] <= wr_data;
        end
        if (rd_en)
            rd_data <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
    end

endmodule

// File: rtl/wall_column_renderer.sv
// Pixel stage after VGA timing: column store lookup, ceiling/wall/floor shading,
// sync realignment. Optional drop counter enabled by DROP_COUNTER_EN.
module wall_column_renderer
    import raybox_pkg::*;
#(
    parameter int HRES     = 640,
    parameter int VRES     = 480,
    parameter int COLSHIFT = 0,
    parameter int HBITS    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       h,
    input  logic [9:0]       v,
    input  logic             visible,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [HBITS-1:0] wr_height,
    input  logic             wr_side,
    output logic             trace_start,
    output logic             frame_dropped,
    output logic [5:0]       rgb,
    output logic             hsync,
    output logic             vsync
`ifdef DROP_COUNTER_EN
    ,
    output logic [7:0]       drop_count
`endif
);

    localparam int COLS = HRES >> COLSHIFT;
    localparam int AW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW   = $clog2(COLS + 1);
    localparam int W    = HBITS + 1;
    localparam int CMPW = ((HBITS > 10) ? HBITS : 10) + 2;

    function automatic logic [5:0] shade(input logic [W-1:0] rec, input logic [9:0] line);
        logic [CMPW-1:0] ht, half, ln, mid;
        ht   = CMPW'(rec[HBITS-1:0]);
        half = ht >> 1;
        ln   = CMPW'(line);
        mid  = CMPW'(VRES / 2);
        if (ht >= CMPW'(VRES))
            shade = rec[HBITS] ? WALL_DARK : WALL_LIGHT;
        else if (ln + half < mid)
            shade = CEIL_RGB;
        else if (ln >= mid + half)
            shade = FLOOR_RGB;
        else
            shade = rec[HBITS] ? WALL_DARK : WALL_LIGHT;
    endfunction

    logic [CW-1:0] wr_cnt;
    logic          front_sel;
    logic          boot;
    logic          wr_fire;
    logic          swap_pt;
    logic [9:0]    col;
    logic [W-1:0]  rd_data;

    assign wr_ready = (wr_cnt < CW'(COLS));
    assign wr_fire  = wr_valid && wr_ready;
    assign swap_pt  = (v == 10'(VRES)) && (h == 10'd0);
    assign col      = h >> COLSHIFT;

    // Swap only with a complete back buffer; otherwise report the drop and keep filling.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt        <= '0;
            front_sel     <= 1'b0;
            boot          <= 1'b1;
            trace_start   <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            boot          <= 1'b0;
            trace_start   <= boot || (swap_pt && !wr_ready);
            frame_dropped <= swap_pt && wr_ready && !boot;
            if (swap_pt && !wr_ready) begin
                front_sel <= ~front_sel;
                wr_cnt    <= '0;
            end else if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    column_store #(.COLS(COLS), .AW(AW), .W(W)) u_store (
        .clk      (clk),
        .wr_en    (wr_fire),
        .wr_addr  (wr_cnt[AW-1:0]),
        .wr_data  ({wr_side, wr_height}),
        .rd_en    (visible),
        .rd_addr  (col[AW-1:0]),
        .front_sel(front_sel),
        .rd_data  (rd_data)
    );

    logic [9:0] v_p1;
    logic       vld_p1, hs_p1, vs_p1;

    // Stage 1: column read in flight; carry line number, visibility and syncs.
    always_ff @(posedge clk) begin
        v_p1 <= v;
        if (reset) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
        end else begin
            vld_p1 <= visible;
            hs_p1  <= hsync_in;
            vs_p1  <= vsync_in;
        end
    end

    // Stage 2: classify pixel and emit colour with aligned syncs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb   <= 6'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            rgb   <= vld_p1 ? shade(rd_data, v_p1) : 6'd0;
            hsync <= hs_p1;
            vsync <= vs_p1;
        end
    end

`ifdef DROP_COUNTER_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        sat_inc = (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)              drop_count <= 8'd0;
        else if (frame_dropped) drop_count <= sat_inc(drop_count);
    end
`endif

endmodule

// File: tb/tb_wall_column_renderer.sv
// Directed bench for wall_column_renderer: reset, fill/swap, dropped frame,
// adjacent column shading, sync alignment, reset mid-fill, optional drop counter.
module tb_wall_column_renderer;
    import raybox_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h, v;
    logic       visible, hsync_in, vsync_in;
    logic       wr_valid, wr_ready, wr_side;
    logic [9:0] wr_height;
    logic       trace_start, frame_dropped, hsync, vsync;
    logic [5:0] rgb;
`ifdef DROP_COUNTER_EN
    logic [7:0] drop_count;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    wall_column_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .h            (h),
        .v            (v),
        .visible      (visible),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_height    (wr_height),
        .wr_side      (wr_side),
        .trace_start  (trace_start),
        .frame_dropped(frame_dropped),
        .rgb          (rgb),
        .hsync        (hsync),
        .vsync        (vsync)
`ifdef DROP_COUNTER_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       vis;
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
    } pix_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_col(input column_t c);
        wr_valid  = 1'b1;
        wr_height = c.height;
        wr_side   = c.side;
        step();
        wr_valid  = 1'b0;
    endtask

    task automatic pix(input pix_t p, input string nm);
        h = p.h; v = p.v; visible = p.vis; hsync_in = p.hs; vsync_in = p.vs;
        step();
        step();
        chk({nm, " rgb"}, rgb, p.rgb);
        chk({nm, " hsync"}, hsync, p.hs);
        chk({nm, " vsync"}, vsync, p.vs);
    endtask

    task automatic swap_point();
        visible = 1'b0; v = 10'd480; h = 10'd0;
        step();
    endtask

    function automatic column_t pattern(input int i);
        column_t c;
        c.side   = (i % 2 == 1);
        c.height = (i % 2 == 1) ? 10'd600 : 10'd0;
        return c;
    endfunction

    pix_t tbl [9];

    initial begin
        column_t c;
        tbl[0] = '{h:10'd10,  v:10'd240, vis:1'b1, hs:1'b1, vs:1'b1, rgb:WALL_LIGHT};
        tbl[1] = '{h:10'd10,  v:10'd100, vis:1'b1, hs:1'b1, vs:1'b1, rgb:CEIL_RGB};
        tbl[2] = '{h:10'd10,  v:10'd400, vis:1'b1, hs:1'b1, vs:1'b1, rgb:FLOOR_RGB};
        tbl[3] = '{h:10'd10,  v:10'd189, vis:1'b1, hs:1'b1, vs:1'b1, rgb:CEIL_RGB};
        tbl[4] = '{h:10'd10,  v:10'd190, vis:1'b1, hs:1'b1, vs:1'b1, rgb:WALL_LIGHT};
        tbl[5] = '{h:10'd10,  v:10'd289, vis:1'b1, hs:1'b1, vs:1'b1, rgb:WALL_LIGHT};
        tbl[6] = '{h:10'd10,  v:10'd290, vis:1'b1, hs:1'b1, vs:1'b1, rgb:FLOOR_RGB};
        tbl[7] = '{h:10'd639, v:10'd240, vis:1'b1, hs:1'b1, vs:1'b1, rgb:WALL_LIGHT};
        tbl[8] = '{h:10'd10,  v:10'd240, vis:1'b0, hs:1'b1, vs:1'b0, rgb:6'd0};

        reset = 1'b1; h = '0; v = '0; visible = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        wr_valid = 1'b0; wr_height = '0; wr_side = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset rgb", rgb, 0);
            chk("reset hsync", hsync, 1);
            chk("reset vsync", vsync, 1);
            chk("reset trace_start", trace_start, 0);
        end
        reset = 1'b0;
        step();
        chk("boot trace_start", trace_start, 1);
        chk("boot wr_ready", wr_ready, 1);
        chk("boot frame_dropped", frame_dropped, 0);
        step();
        chk("boot trace_start cleared", trace_start, 0);

        // Full fill of height 100, light side, then swap.
        c.side = 1'b0; c.height = 10'd100;
        for (int i = 0; i < 640; i++) begin
            if (i == 639) chk("fill ready before last", wr_ready, 1);
            write_col(c);
        end
        chk("fill ready after 640", wr_ready, 0);
        swap_point();
        chk("swap trace_start", trace_start, 1);
        chk("swap no drop", frame_dropped, 0);
        chk("swap ready restored", wr_ready, 1);
        v = 10'd481;
        step();
        chk("swap trace_start single", trace_start, 0);

        for (int i = 0; i < 9; i++) pix(tbl[i], $sformatf("pix%0d", i));

        // Partial fill: drop expected, front unchanged.
        for (int i = 0; i < 100; i++) write_col(pattern(i));
        chk("partial ready", wr_ready, 1);
        swap_point();
        chk("drop pulse", frame_dropped, 1);
        chk("drop no trace_start", trace_start, 0);
        h = 10'd1;
        step();
        chk("drop pulse single", frame_dropped, 0);
        pix(tbl[0], "front kept");
        for (int i = 100; i < 640; i++) write_col(pattern(i));
        chk("refill ready low", wr_ready, 0);
        swap_point();
        chk("retry trace_start", trace_start, 1);
        chk("retry no drop", frame_dropped, 0);

        // Adjacent columns: height 0 then height 600 dark.
        for (int line = 0; line < 480; line++) begin
            pix_t p;
            p = '{h:10'd0, v:10'(line), vis:1'b1, hs:1'b1, vs:1'b1,
                  rgb:(line < 240) ? CEIL_RGB : FLOOR_RGB};
            pix(p, $sformatf("col0 v%0d", line));
            p = '{h:10'd1, v:10'(line), vis:1'b1, hs:1'b1, vs:1'b1, rgb:WALL_DARK};
            pix(p, $sformatf("col1 v%0d", line));
        end

        // Sync alignment.
        h = 10'd656; v = 10'd10; visible = 1'b0; hsync_in = 1'b0;
        step();
        chk("hsync lag 1", hsync, 1);
        step();
        chk("hsync lag 2", hsync, 0);
        chk("hblank rgb", rgb, 0);
        hsync_in = 1'b1; vsync_in = 1'b0;
        step();
        chk("hsync hold", hsync, 0);
        chk("vsync lag 1", vsync, 1);
        step();
        chk("hsync release", hsync, 1);
        chk("vsync lag 2", vsync, 0);
        vsync_in = 1'b1;

        // Reset mid-fill with a visible pixel in flight.
        for (int i = 0; i < 10; i++) write_col(pattern(i));
        h = 10'd10; v = 10'd240; visible = 1'b1; hsync_in = 1'b0;
        step();
        reset = 1'b1; visible = 1'b0; hsync_in = 1'b1;
        step();
        chk("midreset rgb", rgb, 0);
        chk("midreset hsync", hsync, 1);
        reset = 1'b0;
        step();
        chk("midreset trace_start", trace_start, 1);
        for (int i = 0; i < 639; i++) write_col(pattern(i));
        chk("midreset count cleared", wr_ready, 1);
        write_col(pattern(639));
        chk("midreset full", wr_ready, 0);

`ifdef DROP_COUNTER_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("drop_count reset", drop_count, 0);
        for (int i = 0; i < 300; i++) begin
            swap_point();
            h = 10'd1;
            step();
        end
        step();
        chk("drop_count saturated", drop_count, 255);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
